// File: rtl/cover_toggle_sink.sv
// -----------------------------------------------------------------------------
// cover_toggle_sink
//
// Purpose:
//   Hardware receiving end of one toggle-cover group. Every clock edge samples a
//   WIDTH-wide vector of hit pulses, keeps a sticky "covered" map and pushes each
//   newly covered point out exactly once as a global index over a valid/ready
//   stream. A hit sampled at edge E shows up on out_valid after edge E+1: edge E
//   captures it into the pending set and edge E+1 selects it into the output
//   register. Several points pending at once are emitted lowest bit first, one
//   per cycle while out_ready is held high.
//
// Parameters:
//   WIDTH        toggle points in this group (1..1024)
//   COVER_INDEX  global index of bit 0 of this group
//   COVER_TOTAL  total toggle points in the design (COVER_INDEX+WIDTH <= it)
//   IDX_W        width of the emitted index
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-low reset (0 = in reset)
//   clear        sync active-high epoch clear (COVER_TOGGLE_SINK_CLEAR_EN only)
//   valid        per-bit hit pulses, sampled every clock edge
//   out_valid    out_index holds a newly covered index
//   out_ready    consumer accepts the beat when out_valid & out_ready
//   out_index    COVER_INDEX + bit position, zero-extended to IDX_W
//   hit_count    number of distinct points covered so far
//   all_covered  every point of this group is covered
//
// Build option:
//   COVER_TOGGLE_SINK_CLEAR_EN - when defined, adds the clear input. A clear
//   edge zeroes covered, pending, hit_count and all_covered; hits sampled on the
//   same edge land after the zeroing and open the new epoch. A beat already in
//   the output register is kept until accepted. Without the macro, coverage is
//   cleared only by reset.
// -----------------------------------------------------------------------------
module cover_toggle_sink #(
    parameter int unsigned WIDTH       = 65,
    parameter int unsigned COVER_INDEX = 0,
    parameter int unsigned COVER_TOTAL = 38253,
    parameter int unsigned IDX_W       = 64
) (
    input  logic                       clock,
    input  logic                       reset,
`ifdef COVER_TOGGLE_SINK_CLEAR_EN
    input  logic                       clear,
`endif
    input  logic [WIDTH-1:0]           valid,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [IDX_W-1:0]           out_index,
    output logic [$clog2(WIDTH+1)-1:0] hit_count,
    output logic                       all_covered
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // -------------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // -------------------------------------------------------------------------
    if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
        $error("cover_toggle_sink: WIDTH must be in 1..1024");
    end
    if (longint'(COVER_INDEX) + longint'(WIDTH) > longint'(COVER_TOTAL)) begin : g_bad_range
        $error("cover_toggle_sink: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] covered_q, covered_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] out_index_q, out_index_d;
    logic [CW-1:0]    hit_count_q, hit_count_d;
    logic             all_covered_q, all_covered_d;

    // Epoch-clear request; tied off when the option is not built in.
    logic clr;
`ifdef COVER_TOGGLE_SINK_CLEAR_EN
    assign clr = clear;
`else
    assign clr = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] cov_base;   // covered map after an optional clear
    logic [WIDTH-1:0] pend_base;  // pending set after an optional clear
    logic [CW-1:0]    cnt_base;   // hit count after an optional clear
    logic [WIDTH-1:0] new_bits;
    logic [CW-1:0]    new_pop;
    logic [WIDTH-1:0] sel_mask;
    logic [PW-1:0]    sel_idx;
    logic             load;

    always_comb begin
        cov_base  = clr ? '0 : covered_q;
        pend_base = clr ? '0 : pending_q;
        cnt_base  = clr ? '0 : hit_count_q;

        new_bits = valid & ~cov_base;

        new_pop = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            new_pop = new_pop + CW'(new_bits[i]);
        end

        // Lowest set pending bit wins; scanning downwards leaves the lowest last.
        // Only bits pending before this edge are eligible, which gives the
        // capture-then-select latency.
        sel_idx  = '0;
        sel_mask = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (pend_base[i]) begin
                sel_idx     = PW'(i);
                sel_mask    = '0;
                sel_mask[i] = 1'b1;
            end
        end

        load = (!out_valid_q || out_ready) && (pend_base != '0);

        covered_d     = cov_base | new_bits;
        pending_d     = (pend_base | new_bits) & ~(load ? sel_mask : '0);
        hit_count_d   = cnt_base + new_pop;
        all_covered_d = &(cov_base | new_bits);

        out_index_d = out_index_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_index_d = IDX_W'(COVER_INDEX) + IDX_W'(sel_idx);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            covered_q     <= '0;
            pending_q     <= '0;
            out_valid_q   <= 1'b0;
            out_index_q   <= '0;
            hit_count_q   <= '0;
            all_covered_q <= 1'b0;
        end else begin
            covered_q     <= covered_d;
            pending_q     <= pending_d;
            out_valid_q   <= out_valid_d;
            out_index_q   <= out_index_d;
            hit_count_q   <= hit_count_d;
            all_covered_q <= all_covered_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_index   = out_index_q;
    assign hit_count   = hit_count_q;
    assign all_covered = all_covered_q;

    // -------------------------------------------------------------------------
    // Protocol checks
    // -------------------------------------------------------------------------
`ifndef SYNTHESIS
    // A stalled beat must not change or vanish.
    a_hold_beat : assert property (@(posedge clock) disable iff (!reset)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_index)));

    a_count_bound : assert property (@(posedge clock) disable iff (!reset)
        (32'(hit_count) <= WIDTH));

    // A point is never both waiting to be emitted and uncovered.
    a_pending_covered : assert property (@(posedge clock) disable iff (!reset)
        ((pending_q & ~covered_q) == '0));
`endif

endmodule
